// File: rtl/mul_seq.sv
// Sequential shift-add unsigned multiplier with architectural HI/LO registers.
// One multiply step per cycle; HI/LO update only when the full product is ready.
module mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     sum;
    logic [CW-1:0]      cnt;
    logic               last;
    logic               accept;

    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = start && ((state == IDLE) || (state == DONE));

    // Carry out of the add becomes the new MSB after the right shift.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, mcand} & {(WIDTH+1){acc[0]}});
        acc_step = {sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (accept) begin
            mcand <= op_a;
            acc   <= {{WIDTH{1'b0}}, op_b};
            cnt   <= '0;
        end else if (state == RUN) begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
            if (last) begin
                hi <= acc_step[2*WIDTH-1:WIDTH];
                lo <= acc_step[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        case (rd_sel)
            2'b01:   rd_data = hi;
            2'b10:   rd_data = lo;
            default: rd_data = '0;
        endcase
    end

    assign stall = busy && (start || (rd_sel == 2'b01) || (rd_sel == 2'b10));

endmodule

// File: tb/tb_mul_seq.sv
// Randomized scoreboard bench for mul_seq: expected products and timing are queued
// at issue time and checked by an independent monitor on the falling edge.
module tb_mul_seq;

    localparam int unsigned W = 32;

    typedef struct {
        int unsigned      sc;
        logic [2*W-1:0]   prod;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [1:0]   rd_sel = 2'b00;
    logic [W-1:0] rd_data, hi, lo;
    logic         busy, done, stall;

    exp_t         q[$];
    int unsigned  cyc = 0;
    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    mul_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .rd_sel  (rd_sel),
        .rd_data (rd_data),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, req);
        end
    endfunction

    // Monitor: expectations derived only from the queued issue cycle and product.
    always @(negedge clk) begin
        logic         exp_busy, exp_done;
        logic [W-1:0] exp_rd;
        exp_t         e;
        if (rst) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
            if (q.size() > 0) begin
                exp_busy = (cyc >= q[0].sc + 1) && (cyc <= q[0].sc + W);
                exp_done = (cyc == q[0].sc + W + 1);
            end
            check("busy", W'(busy), W'(exp_busy));
            check("done", W'(done), W'(exp_done));
            if (exp_done) begin
                e = q.pop_front();
                model_hi = e.prod[2*W-1:W];
                model_lo = e.prod[W-1:0];
            end
            check("hi", hi, model_hi);
            check("lo", lo, model_lo);
            exp_rd = (rd_sel == 2'b01) ? model_hi : (rd_sel == 2'b10) ? model_lo : '0;
            check("rd_data", rd_data, exp_rd);
            check("stall", W'(stall),
                  W'(exp_busy && (start || rd_sel == 2'b01 || rd_sel == 2'b10)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        e.sc   = cyc;
        e.prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        q.push_back(e);
        tick();
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (q.size() > 0 && n < 2 * W + 10) begin
            tick();
            n++;
        end
        n_vec++;
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL wait_idle: %0d products still pending, expected 0", q.size());
            q.delete();
        end
        tick();
    endtask

    task automatic junk_start();
        op_a  = 7;
        op_b  = $urandom;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
    endtask

    initial begin
        int unsigned s;
        logic [W-1:0] a, b;

        repeat (3) tick();
        check_reset_state();

        // First start accepted together with reset release; junk start during RUN ignored.
        rst = 1'b1;
        issue(3, 5);
        repeat (5) tick();
        junk_start();
        wait_idle();

        issue('1, '1);
        wait_idle();
        issue(32'h8000_0000, 2);
        wait_idle();

        // HI = 0x12 committed, then mfhi held across a whole multiply.
        issue(32'h0001_2000, 32'h0010_0000);
        wait_idle();
        rd_sel = 2'b01;
        issue($urandom, $urandom);
        wait_idle();
        rd_sel = 2'b10;
        issue($urandom, $urandom);
        wait_idle();
        rd_sel = 2'b00;

        // Back-to-back: second start in the DONE cycle of the first.
        s = cyc;
        issue(2, 3);
        while (cyc < s + W + 1) tick();
        issue(4, 6);
        wait_idle();

        // Reset at RUN cycle 10 aborts the multiply.
        s = cyc;
        issue($urandom, $urandom);
        while (cyc < s + 10) tick();
        rst = 1'b0;
        q.delete();
        tick();
        check_reset_state();
        model_hi = '0;
        model_lo = '0;
        rst = 1'b1;
        issue(2, 2);
        wait_idle();

        for (int i = 0; i < 14; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) a = 0;
            if (i % 4 == 2) b = '1;
            rd_sel = 2'($urandom);
            issue(a, b);
            if (i % 3 == 0) begin
                repeat ($urandom_range(1, W - 2)) tick();
                junk_start();
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
